// File: rtl/ped_xing_pkg.sv
// Shared types and helpers for the pedestrian crossing controller.
// State encoding plus the vehicle-light sanity check.
package ped_xing_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    WAIT,
    WALK,
    FLASH,
    CLEAR,
    FAULT
  } state_e;

  // True when exactly one of red/yellow/green is lit.
  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/ped_btn_sync.sv
// Two-flop synchronizer plus rising-edge detect for the push button.
// Used by ped_crossing_ctrl only when PED_BTN_SYNC_EN is defined.
module ped_btn_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic s1_q, s2_q, s3_q;

  // Shift the raw button through the sync chain plus one history flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign o_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle traffic light.
// Define PED_BTN_SYNC_EN to treat i_btn as asynchronous (sync + edge).
module ped_crossing_ctrl #(
  parameter int WALK_TIME   = 5,
  parameter int FLASH_TIME  = 4,
  parameter int BLINK_HALF  = 1,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_red,
  input  logic                   i_yellow,
  input  logic                   i_green,
  input  logic                   i_btn,
  output logic                   o_walk,
  output logic                   o_dont_walk,
  output logic                   o_req_pending,
  output logic [COUNT_WIDTH-1:0] o_countdown,
  output logic                   o_fault
);

  import ped_xing_pkg::*;

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  // The countdown includes the current cycle, so it opens at the
  // full walk+flash length and shows 1 in the last flash cycle.
  localparam logic [COUNT_WIDTH-1:0] CD_LOAD =
    COUNT_WIDTH'(WALK_TIME + FLASH_TIME);
  localparam logic [COUNT_WIDTH-1:0] CD_WALK_END =
    COUNT_WIDTH'(FLASH_TIME + 1);
  localparam logic [COUNT_WIDTH-1:0] CD_ONE =
    COUNT_WIDTH'(1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);

  state_e state_q, state_d;
  logic   red_q;
  logic   btn;
  logic   red_start;
  logic   req_any;

  logic                   walk_q, walk_d;
  logic                   dw_q, dw_d;
  logic                   req_q, req_d;
  logic [COUNT_WIDTH-1:0] cd_q, cd_d;
  logic                   fault_q, fault_d;
  logic [BW-1:0]          blink_q, blink_d;

`ifdef PED_BTN_SYNC_EN
  ped_btn_sync u_btn_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn),
    .o_pulse (btn)
  );
`else
  assign btn = i_btn;
`endif

  // Next state; a bad light pattern overrides everything.
  always_comb begin
    red_start = i_red & ~red_q;
    req_any   = req_q | btn;
    state_d   = state_q;
    case (state_q)
      IDLE:
        if (btn) state_d = WAIT;
      WAIT:
        if (red_start) state_d = WALK;
      WALK:
        if (!i_red) state_d = req_q ? WAIT : IDLE;
        else if (cd_q == CD_WALK_END) state_d = FLASH;
      FLASH:
        if (!i_red) state_d = req_any ? WAIT : IDLE;
        else if (cd_q == CD_ONE) state_d = CLEAR;
      CLEAR:
        if (!i_red) state_d = req_any ? WAIT : IDLE;
      default:
        state_d = FAULT;
    endcase
    if (!onehot3({i_red, i_yellow, i_green})) state_d = FAULT;
  end

  // Output values for the state being entered.
  always_comb begin
    walk_d  = 1'b0;
    dw_d    = 1'b1;
    req_d   = 1'b0;
    cd_d    = '0;
    fault_d = 1'b0;
    blink_d = blink_q;
    case (state_d)
      WAIT:
        req_d = 1'b1;
      WALK: begin
        walk_d = 1'b1;
        dw_d   = 1'b0;
        cd_d   = (state_q == WALK) ? cd_q - 1'b1 : CD_LOAD;
      end
      FLASH: begin
        req_d = req_q | (btn & (state_q != WALK));
        cd_d  = cd_q - 1'b1;
        if (state_q != FLASH) begin
          dw_d    = 1'b1;
          blink_d = BLINK_LOAD;
        end else if (blink_q == '0) begin
          dw_d    = ~dw_q;
          blink_d = BLINK_LOAD;
        end else begin
          dw_d    = dw_q;
          blink_d = blink_q - 1'b1;
        end
      end
      CLEAR:
        req_d = req_any;
      FAULT:
        fault_d = 1'b1;
      default: ;
    endcase
  end

  // State, red history and all outputs are registered together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      red_q   <= 1'b0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      req_q   <= 1'b0;
      cd_q    <= '0;
      fault_q <= 1'b0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      red_q   <= i_red;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      req_q   <= req_d;
      cd_q    <= cd_d;
      fault_q <= fault_d;
      blink_q <= blink_d;
    end
  end

  assign o_walk        = walk_q;
  assign o_dont_walk   = dw_q;
  assign o_req_pending = req_q;
  assign o_countdown   = cd_q;
  assign o_fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl driven by a traffic-light model.
// Define PED_BTN_SYNC_EN to run the synchronized-button scenario.
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r = 1'b0, y = 1'b0, g = 1'b0, b = 1'b0;
  logic       o_walk, o_dw, o_req, o_fault;
  logic [4:0] o_cd;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int glow = 10;
  logic force_bad = 1'b0;

  logic [8:0] obs, exp;
  logic       ew, edw, er, ef;
  int         ecd;

  ped_crossing_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_red         (r),
    .i_yellow      (y),
    .i_green       (g),
    .i_btn         (b),
    .o_walk        (o_walk),
    .o_dont_walk   (o_dw),
    .o_req_pending (o_req),
    .o_countdown   (o_cd),
    .o_fault       (o_fault)
  );

  always #5 clk = ~clk;

  // Lights for cycle cyc: red glow, yellow 10, green 10, yellow 10.
  task automatic set_lights();
    int p, pos;
    p = glow + 30;
    pos = cyc % p;
    r = (pos < glow);
    g = (pos >= glow + 10) && (pos < glow + 20);
    y = !r && !g;
    if (force_bad) begin
      r = 1'b1;
      g = 1'b1;
      y = 1'b0;
    end
  endtask

  task automatic drive(input logic btn);
    set_lights();
    b = btn;
    @(negedge clk);
    obs = {o_walk, o_dw, o_req, o_cd, o_fault};
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int gl);
    rst_n = 1'b0;
    glow = gl;
    force_bad = 1'b0;
    cyc = 0;
    b = 1'b0;
    set_lights();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_exp();
    ew = 1'b0; edw = 1'b1; er = 1'b0; ecd = 0; ef = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {o_walk, o_dw, o_req, o_cd, o_fault};
    exp = 9'b0_1_0_00000_0;
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL reset got=%b want=%b", obs, exp);
    end
    do_reset(10);
    drive(1'b0);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL reset_cyc0 got=%b want=%b", obs, exp);
    end
  endtask

  task automatic test_idle();
    do_reset(10);
    for (int c = 0; c < 80; c++) begin
      drive(1'b0);
      exp = 9'b0_1_0_00000_0;
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL idle cyc=%0d got=%b want=%b", c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_walk();
    do_reset(10);
    for (int c = 0; c < 56; c++) begin
      drive(c == 25);
      idle_exp();
      if (c >= 26 && c <= 40) er = 1'b1;
      if (c >= 41 && c <= 45) begin
        ew = 1'b1; edw = 1'b0; ecd = 9 - (c - 41);
      end
      if (c >= 46 && c <= 49) begin
        edw = ((c - 46) % 2 == 0); ecd = 4 - (c - 46);
      end
      exp = {ew, edw, er, 5'(ecd), ef};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL walk cyc=%0d got=%b want=%b", c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_early_end(input int gl);
    int p, k;
    do_reset(gl);
    p = gl + 30;
    for (int c = 0; c <= p + gl + 5; c++) begin
      drive(c == 18);
      idle_exp();
      if (c >= 19 && c <= p) er = 1'b1;
      if (c >= p + 1 && c <= p + gl) begin
        k = c - (p + 1);
        if (k < 5) begin
          ew = 1'b1; edw = 1'b0; ecd = 9 - k;
        end else begin
          edw = ((k - 5) % 2 == 0); ecd = 4 - (k - 5);
        end
      end
      exp = {ew, edw, er, 5'(ecd), ef};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL early_end_g%0d cyc=%0d got=%b want=%b",
                 gl, c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_fault();
    do_reset(10);
    for (int c = 0; c < 62; c++) begin
      force_bad = (c == 30);
      drive(c == 25);
      idle_exp();
      if (c >= 26 && c <= 30) er = 1'b1;
      if (c >= 31) ef = 1'b1;
      exp = {ew, edw, er, 5'(ecd), ef};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL fault cyc=%0d got=%b want=%b", c, obs, exp);
      end
      advance();
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {o_walk, o_dw, o_req, o_cd, o_fault};
    exp = 9'b0_1_0_00000_0;
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL fault_clear got=%b want=%b", obs, exp);
    end
  endtask

  task automatic test_async_reset();
    do_reset(10);
    for (int c = 0; c <= 43; c++) begin
      drive(c == 25);
      if (c < 43) advance();
    end
    exp = 9'b1_0_0_00111_0;
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL pre_async got=%b want=%b", obs, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {o_walk, o_dw, o_req, o_cd, o_fault};
    exp = 9'b0_1_0_00000_0;
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL async_reset got=%b want=%b", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(10);
    for (int c = 0; c < 87; c++) begin
      drive(c == 25 || c == 43 || c == 47);
      idle_exp();
      if (c >= 26 && c <= 40) er = 1'b1;
      if (c >= 41 && c <= 45) begin
        ew = 1'b1; edw = 1'b0; ecd = 9 - (c - 41);
      end
      if (c >= 46 && c <= 49) begin
        edw = ((c - 46) % 2 == 0); ecd = 4 - (c - 46);
      end
      if (c >= 48 && c <= 80) er = 1'b1;
      if (c >= 81 && c <= 85) begin
        ew = 1'b1; edw = 1'b0; ecd = 9 - (c - 81);
      end
      if (c == 86) begin
        edw = 1'b1; ecd = 4;
      end
      exp = {ew, edw, er, 5'(ecd), ef};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b",
                 c, obs, exp);
      end
      advance();
    end
  endtask

  task automatic test_btn_red_start();
    do_reset(10);
    for (int c = 0; c < 83; c++) begin
      drive(c == 40);
      idle_exp();
      if (c >= 41 && c <= 80) er = 1'b1;
      if (c >= 81) begin
        ew = 1'b1; edw = 1'b0; ecd = 9 - (c - 81);
      end
      exp = {ew, edw, er, 5'(ecd), ef};
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL btn_red_start cyc=%0d got=%b want=%b",
                 c, obs, exp);
      end
      advance();
    end
  endtask

`ifdef PED_BTN_SYNC_EN
  task automatic test_btn_sync();
    int   walks;
    logic pw;
    walks = 0;
    pw = 1'b0;
    do_reset(10);
    for (int c = 0; c < 121; c++) begin
      drive(c >= 25 && c <= 54);
      if (o_walk && !pw) walks++;
      pw = o_walk;
      if (c == 27 || c == 28) begin
        nvec++;
        if (o_req !== (c == 28)) begin
          nerr++;
          $display("FAIL sync_latency cyc=%0d got=%b want=%b",
                   c, o_req, (c == 28));
        end
      end
      if (c == 41) begin
        nvec++;
        if (o_walk !== 1'b1) begin
          nerr++;
          $display("FAIL sync_walk got=%b want=1", o_walk);
        end
      end
      advance();
    end
    nvec++;
    if (walks != 1) begin
      nerr++;
      $display("FAIL sync_one_walk got=%0d want=1", walks);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
`ifdef PED_BTN_SYNC_EN
    test_btn_sync();
`else
    test_walk();
    test_early_end(4);
    test_early_end(6);
    test_fault();
    test_async_reset();
    test_back_to_back();
    test_btn_red_start();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
